fsm: RTL and testbench

FSM -- requirements
Module: fsm

---
 rtl/fsm.sv | 108 ++++++++++
 tb/tb_fsm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm.sv
// fsm: vending controller (select -> pay -> dispense) with per-state timeouts; define FSM_PB_DEBOUNCE_EN to debounce pushbutton
module fsm #(
  parameter int         NUM_ITEMS       = 4,
  parameter logic [3:0] PAY_CODE        = 4'b0010,
  parameter int         SEL_TIMEOUT     = 1000,
  parameter int         PAY_TIMEOUT     = 1000,
  parameter int         DISP_TIMEOUT    = 500,
  parameter int         BUZZ_CYCLES     = 4,
  parameter int         ERR_CYCLES      = 8,
  parameter int         DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pushbutton,
  input  logic [3:0] keypad,
  input  logic       IR_Sensor,
  output logic [2:0] current_state,
  output logic       red_led,
  output logic [2:0] green_leds,
  output logic       DC_motor,
  output logic       buzzer
);
  localparam logic [2:0] IDLE     = 3'b000;
  localparam logic [2:0] SELECT   = 3'b001;
  localparam logic [2:0] PAYMENT  = 3'b010;
  localparam logic [2:0] DISPENSE = 3'b011;
  localparam logic [2:0] COMPLETE = 3'b100;
  localparam logic [2:0] ERROR    = 3'b101;
  localparam logic [3:0] NI = 4'(NUM_ITEMS);
  // each timer limit is the last count value before leaving, so a state lasts exactly N cycles
  localparam logic [15:0] SEL_LAST  = 16'(SEL_TIMEOUT - 1);
  localparam logic [15:0] PAY_LAST  = 16'(PAY_TIMEOUT - 1);
  localparam logic [15:0] DISP_LAST = 16'(DISP_TIMEOUT - 1);
  localparam logic [15:0] BUZZ_LAST = 16'(BUZZ_CYCLES - 1);
  localparam logic [15:0] ERR_LAST  = 16'(ERR_CYCLES - 1);
  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        rel_q, rel_d;
  logic [3:0]  item_q, item_d;
  logic        pb_evt;
  logic        item_ok;
`ifdef FSM_PB_DEBOUNCE_EN
  localparam logic [15:0] DEB_N = 16'(DEBOUNCE_CYCLES);
  logic [15:0] deb_q, deb_d;
  // count consecutive high samples, saturating so a long press fires only once
  always_comb begin
    deb_d  = !pushbutton ? 16'd0 : (deb_q == DEB_N) ? deb_q : deb_q + 16'd1;
    pb_evt = pushbutton && (deb_q == DEB_N - 16'd1);
  end
  // debounce counter register
  always_ff @(posedge clk or negedge reset)
    if (!reset) deb_q <= '0;
    else deb_q <= deb_d;
`else
  logic pb_q;
  // previous pushbutton sample for rising-edge detection
  always_ff @(posedge clk or negedge reset)
    if (!reset) pb_q <= 1'b0;
    else pb_q <= pushbutton;
  assign pb_evt = pushbutton && !pb_q;
`endif
  assign item_ok = (keypad != 4'd0) && (keypad <= NI);
  // state, timer, release flag and latched item registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      rel_q   <= 1'b0;
      item_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rel_q   <= rel_d;
      item_q  <= item_d;
    end
  // next-state, timer, release flag and item latch; valid inputs take priority over timeouts
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:     state_d = pb_evt ? SELECT : IDLE;
      SELECT:   state_d = item_ok ? PAYMENT : (keypad != 4'd0) ? ERROR :
                          (timer_q >= SEL_LAST) ? IDLE : SELECT;
      PAYMENT:  state_d = (rel_q && keypad == PAY_CODE && item_q != 4'd0) ? DISPENSE :
                          (rel_q && keypad != 4'd0) ? ERROR :
                          (timer_q >= PAY_LAST) ? IDLE : PAYMENT;
      DISPENSE: state_d = IR_Sensor ? COMPLETE : (timer_q >= DISP_LAST) ? ERROR : DISPENSE;
      COMPLETE: state_d = (timer_q >= BUZZ_LAST) ? IDLE : COMPLETE;
      ERROR:    state_d = (timer_q >= ERR_LAST) ? IDLE : ERROR;
      default:  state_d = IDLE;
    endcase
    timer_d = (state_d != state_q) ? 16'd0 : (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    rel_d   = (state_d != state_q) ? 1'b0 : (state_q == PAYMENT && keypad == 4'd0) ? 1'b1 : rel_q;
    item_d  = (state_q == SELECT && item_ok) ? keypad : item_q;
  end
  assign current_state = state_q;
  // Moore output decode; illegal encodings fall back to IDLE outputs
  always_comb begin
    {red_led, green_leds, DC_motor, buzzer} = 6'b1_000_0_0;
    case (state_q)
      SELECT:   {red_led, green_leds, DC_motor, buzzer} = 6'b0_001_0_0;
      PAYMENT:  {red_led, green_leds, DC_motor, buzzer} = 6'b0_011_0_0;
      DISPENSE: {red_led, green_leds, DC_motor, buzzer} = 6'b0_111_1_0;
      COMPLETE: {red_led, green_leds, DC_motor, buzzer} = 6'b0_111_0_1;
      ERROR:    {red_led, green_leds, DC_motor, buzzer} = 6'b1_000_0_1;
      default:  {red_led, green_leds, DC_motor, buzzer} = 6'b1_000_0_0;
    endcase
  end
endmodule

// File: tb/tb_fsm.sv
// tb_fsm: randomized and directed checks of fsm against a cycle-level behavioural model
module tb_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pushbutton = 1'b0;
  logic [3:0] keypad = 4'd0;
  logic       IR_Sensor = 1'b0;
  logic [2:0] current_state;
  logic       red_led;
  logic [2:0] green_leds;
  logic       DC_motor;
  logic       buzzer;
  int tests = 0;
  int fails = 0;
  int m_state = 0;
  int m_cnt = 0;
  bit m_rel = 0;
  bit m_prev = 0;
  int m_hold = 0;
  fsm dut (
    .clk(clk), .reset(reset), .pushbutton(pushbutton), .keypad(keypad), .IR_Sensor(IR_Sensor),
    .current_state(current_state), .red_led(red_led), .green_leds(green_leds),
    .DC_motor(DC_motor), .buzzer(buzzer)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] exp_out(input int s);
    case (s)
      1: return 16'b0_001_0_0;
      2: return 16'b0_011_0_0;
      3: return 16'b0_111_1_0;
      4: return 16'b0_111_0_1;
      5: return 16'b1_000_0_1;
      default: return 16'b1_000_0_0;
    endcase
  endfunction
  function automatic logic [15:0] dut_out();
    return 16'({red_led, green_leds, DC_motor, buzzer});
  endfunction
  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_rel = 0; m_prev = 0; m_hold = 0;
  endtask
  // one clock edge of the reference: el = cycles spent in the current state including this one
  task automatic model_step();
    int nxt, el;
    bit ev;
    el = m_cnt + 1;
`ifdef FSM_PB_DEBOUNCE_EN
    ev = pushbutton && (m_hold == 3);
    m_hold = pushbutton ? m_hold + 1 : 0;
`else
    ev = pushbutton && !m_prev;
`endif
    m_prev = pushbutton;
    nxt = m_state;
    case (m_state)
      0: if (ev) nxt = 1;
      1: if (keypad >= 1 && keypad <= 4) nxt = 2;
         else if (keypad != 0) nxt = 5;
         else if (el >= 1000) nxt = 0;
      2: if (m_rel && keypad == 2) nxt = 3;
         else if (m_rel && keypad != 0) nxt = 5;
         else if (el >= 1000) nxt = 0;
      3: if (IR_Sensor) nxt = 4;
         else if (el >= 500) nxt = 5;
      4: if (el >= 4) nxt = 0;
      5: if (el >= 8) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_state) begin
      m_cnt = 0;
      m_rel = 0;
    end else begin
      m_cnt++;
      if (m_state == 2 && keypad == 0) m_rel = 1;
    end
    m_state = nxt;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("state", 16'(current_state), 16'(m_state));
    chk("outs", dut_out(), exp_out(m_state));
  endtask
  task automatic press();
    pushbutton = 1'b0;
    tick();
    pushbutton = 1'b1;
    for (int i = 0; i < 10 && m_state == 0; i++) tick();
    pushbutton = 1'b0;
  endtask
  task automatic to_disp();
    press();
    keypad = 4'd1; tick();
    keypad = 4'd0; tick();
    keypad = 4'd2; tick();
    keypad = 4'd0;
  endtask
  task automatic to_idle();
    pushbutton = 1'b0; keypad = 4'd0; IR_Sensor = 1'b0;
    for (int i = 0; i < 1100 && m_state != 0; i++) tick();
  endtask
  initial begin
    int n, trans, prev;
    #12;
    chk("rst_state", 16'(current_state), 16'd0);
    chk("rst_outs", dut_out(), 16'b1_000_0_0);
    model_reset();
    reset = 1'b1;
    tick();
    // happy path
    to_disp();
    chk("happy_disp", 16'(current_state), 16'd3);
    chk("happy_motor", 16'(DC_motor), 16'd1);
    tick(); tick();
    IR_Sensor = 1'b1; tick(); IR_Sensor = 1'b0;
    n = (buzzer === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10 && current_state == 3'd4; i++) begin
      tick();
      if (current_state == 3'd4 && buzzer === 1'b1) n++;
    end
    chk("happy_buzz_cycles", 16'(n), 16'd4);
    chk("happy_end_idle", 16'(current_state), 16'd0);
    // invalid item code
    press();
    keypad = 4'b0110; tick(); keypad = 4'd0;
    chk("err_state", 16'(current_state), 16'd5);
    n = (red_led && buzzer) ? 1 : 0;
    for (int i = 0; i < 20 && current_state == 3'd5; i++) begin
      tick();
      if (current_state == 3'd5 && red_led && buzzer) n++;
    end
    chk("err_cycles", 16'(n), 16'd8);
    chk("err_end_idle", 16'(current_state), 16'd0);
    // payment without release times out
    press();
    keypad = 4'd1; tick();
    n = (current_state == 3'd2) ? 1 : 0;
    for (int i = 0; i < 1100 && current_state == 3'd2; i++) begin
      if (i == 10) keypad = 4'd2;
      tick();
      if (current_state == 3'd2) n++;
    end
    chk("pay_timeout_cycles", 16'(n), 16'd1000);
    chk("pay_timeout_idle", 16'(current_state), 16'd0);
    keypad = 4'd0;
    // dispense timeout
    to_disp();
    n = (current_state == 3'd3) ? 1 : 0;
    for (int i = 0; i < 600 && current_state == 3'd3; i++) begin
      tick();
      if (current_state == 3'd3) n++;
    end
    chk("disp_timeout_cycles", 16'(n), 16'd500);
    chk("disp_timeout_err", 16'(current_state), 16'd5);
    chk("disp_timeout_motor", 16'(DC_motor), 16'd0);
    to_idle();
    // asynchronous reset while the motor runs
    to_disp();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", 16'(current_state), 16'd0);
    chk("async_rst_outs", dut_out(), 16'b1_000_0_0);
    model_reset();
    #2 reset = 1'b1;
    tick();
    // long press fires once, even after returning to IDLE
    pushbutton = 1'b0; tick();
    pushbutton = 1'b1; keypad = 4'b0110;
    trans = 0;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (prev == 0 && current_state == 3'd1) trans++;
      prev = int'(current_state);
    end
    chk("hold_transitions", 16'(trans), 16'd1);
    to_idle();
`ifdef FSM_PB_DEBOUNCE_EN
    pushbutton = 1'b1; tick(); pushbutton = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("deb_short_pulse", 16'(current_state), 16'd0);
`endif
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      pushbutton = ($urandom_range(0, 3) == 0);
      IR_Sensor = ($urandom_range(0, 7) == 0);
      if (r == 4) keypad = 4'd2;
      else if (r == 5) keypad = 4'($urandom_range(1, 4));
      else if (r == 6) keypad = 4'($urandom_range(0, 15));
      else if (r < 4) keypad = 4'd0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
